// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // One-hot-low column drive for a column index.
  function automatic logic [NUM_COLS-1:0] col_decode(input logic [1:0] idx);
    col_decode = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/SCAN_HZ clocks.
module scan_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick is high while the counter sits on its last value, so the first
  // tick is registered TICK_DIV edges after reset is released.
  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: column-at-a-time drive, row sampling on tick,
// single-key debounce on press and release, one-cycle strobe on acceptance.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DS_C = CW'(DEBOUNCE_SCANS);

  logic          tick;
  logic [3:0]    row_s1_q, row_s2_q;
  state_e        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    pat_q, pat_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    col_q, col_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic          is_single, is_idle, accept;
  logic [1:0]    low_row;

  scan_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick_o(tick)
  );

  always_comb begin
    is_single = ($countones(~row_s2_q) == 1);
    is_idle   = (row_s2_q == 4'b1111);
    low_row   = 2'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!row_s2_q[i]) low_row = 2'(i);
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    accept      = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (is_single) begin
            row_idx_d = low_row;
            pat_d     = row_s2_q;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = PRESSED;
              cnt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s2_q == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS_C) begin
              accept  = 1'b1;
              state_d = PRESSED;
              cnt_d   = '0;
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 1'b1;
            cnt_d     = '0;
          end
        end
        PRESSED: begin
          // Any non-idle tick restarts the release count, so short bounces
          // on release never produce a second strobe.
          if (is_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS_C) begin
              key_down_d = 1'b0;
              state_d    = SCAN;
              col_idx_d  = col_idx_q + 1'b1;
              cnt_d      = '0;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    if (accept) begin
      key_code_d  = {row_idx_d, col_idx_q};
      key_down_d  = 1'b1;
      key_valid_d = 1'b1;
    end
    col_d = col_decode(col_idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q    <= 4'b1111;
      row_s2_q    <= 4'b1111;
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      pat_q       <= 4'b1111;
      cnt_q       <= '0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix model drives rows from col and a key mask;
// expectations come from tick timing arithmetic (tick every 10 cycles).
module tb_keypad_scanner;

  localparam int TICK = 10;
  localparam int DS   = 3;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] key_mask;

  int total;
  int bad;

  keypad_scanner #(
    .CLK_HZ        (1000),
    .SCAN_HZ       (100),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: row r is pulled low by any pressed key (r,c) whose column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mask[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] col_of(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (k % 4));
  endfunction

  // Cycle n counts edges since reset release; ticks are sampled in cycles with
  // n%10==9, the column during that cycle is (n/10)%4 while scanning freely,
  // and a row change in cycle p reaches the decision logic in cycle p+2.
  function automatic int first_tick(input int p, input int c);
    for (int t = p + 2; t < p + 200; t++) begin
      if ((t % TICK) == TICK - 1 && ((t / TICK) % 4) == c) return t;
    end
    return -1;
  endfunction

  function automatic int nth_tick_after(input int q, input int k);
    int seen;
    seen = 0;
    for (int t = q + 2; t < q + 200; t++) begin
      if ((t % TICK) == TICK - 1) begin
        seen++;
        if (seen == k) return t;
      end
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    key_mask = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", col); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    total++; if (key_down !== 1'b0) begin bad++; $display("FAIL reset_down got=%b exp=0", key_down); end
    do_reset();
    for (int n = 0; n <= 45; n++) begin
      total++;
      if (col !== col_of(n / TICK)) begin
        bad++; $display("FAIL rotate_col n=%0d got=%b exp=%b", n, col, col_of(n / TICK));
      end
      step();
    end
  endtask

  // Key (r,c) plus optional extra keys held over cycles [p,q), released during [gs,ge).
  task automatic run_key(input int r, input int c, input int p, input int q,
                         input int gs, input int ge, input logic [15:0] extra);
    int t_det, strobe, t_rel;
    logic [3:0] exp_code;
    logic [15:0] one_key;
    one_key  = 16'd1 << (r * 4 + c);
    exp_code = 4'(4 * r + c);
    t_det    = first_tick(p, c);
    strobe   = t_det + (DS - 1) * TICK + 1;
    t_rel    = nth_tick_after(q, DS) + 1;
    for (int n = 0; n <= t_rel + 15; n++) begin
      key_mask = (n >= p && n < q && !(n >= gs && n < ge)) ? (one_key | extra) : 16'd0;
      total++;
      if (key_valid !== (n == strobe)) begin
        bad++; $display("FAIL key_valid key=%0d n=%0d got=%b exp=%b", exp_code, n, key_valid, (n == strobe));
      end
      total++;
      if (key_down !== (n >= strobe && n < t_rel)) begin
        bad++; $display("FAIL key_down key=%0d n=%0d got=%b exp=%b", exp_code, n, key_down, (n >= strobe && n < t_rel));
      end
      if (n == strobe) begin
        total++;
        if (key_code !== exp_code) begin
          bad++; $display("FAIL key_code n=%0d got=%0d exp=%0d", n, key_code, exp_code);
        end
      end
      if (n == t_rel) begin
        total++;
        if (col !== col_of(c + 1)) begin
          bad++; $display("FAIL resume_col key=%0d got=%b exp=%b", exp_code, col, col_of(c + 1));
        end
      end
      step();
    end
    total++;
    if (key_code !== exp_code) begin
      bad++; $display("FAIL code_hold got=%0d exp=%0d", key_code, exp_code);
    end
  endtask

  task automatic test_single_key();
    do_reset();
    run_key(2, 1, 0, 100, 0, 0, 16'd0);
  endtask

  task automatic test_glitch();
    do_reset();
    for (int n = 0; n <= 100; n++) begin
      key_mask = (n >= 32 && n < 40) ? (16'd1 << 3) : 16'd0;
      total++;
      if (key_valid !== 1'b0 || key_down !== 1'b0) begin
        bad++; $display("FAIL glitch_out n=%0d got=%b%b exp=00", n, key_valid, key_down);
      end
      if (n == 45) begin
        total++;
        if (col !== 4'b0111) begin bad++; $display("FAIL glitch_hold got=%b exp=0111", col); end
      end
      if (n == 55) begin
        total++;
        if (col !== 4'b1110) begin bad++; $display("FAIL glitch_resume got=%b exp=1110", col); end
      end
      step();
    end
  endtask

  task automatic test_multi();
    do_reset();
    for (int n = 0; n <= 150; n++) begin
      key_mask = (16'd1 << 2) | (16'd1 << 14);
      total++;
      if (key_valid !== 1'b0 || key_down !== 1'b0) begin
        bad++; $display("FAIL multi_out n=%0d got=%b%b exp=00", n, key_valid, key_down);
      end
      total++;
      if (col !== col_of(n / TICK)) begin
        bad++; $display("FAIL multi_col n=%0d got=%b exp=%b", n, col, col_of(n / TICK));
      end
      step();
    end
    key_mask = '0;
    do_reset();
    run_key(1, 0, 0, 100, 0, 0, 16'd1 << 7);
  endtask

  task automatic test_release_bounce();
    do_reset();
    run_key(2, 1, 0, 120, 50, 70, 16'd0);
  endtask

  task automatic test_reset_in_pressed();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      key_mask = 16'd1 << 9;
      total++;
      if (key_valid !== (n == 40)) begin
        bad++; $display("FAIL pre_reset_valid n=%0d got=%b exp=%b", n, key_valid, (n == 40));
      end
      step();
    end
    reset = 1'b1;
    #1;
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL mid_reset_col got=%b exp=1110", col); end
    total++; if (key_down !== 1'b0) begin bad++; $display("FAIL mid_reset_down got=%b exp=0", key_down); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", key_valid); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL mid_reset_code got=%0d exp=0", key_code); end
    do_reset();
    run_key(2, 1, 0, 60, 0, 0, 16'd0);
  endtask

  task automatic test_random_keys();
    int r, c, p, q, t_det;
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      p = $urandom_range(0, 60);
      t_det = first_tick(p, c);
      q = t_det + (DS - 1) * TICK + 5 + $urandom_range(0, 60);
      key_mask = '0;
      do_reset();
      run_key(r, c, p, q, 0, 0, 16'd0);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    key_mask = '0;
    test_reset();
    test_single_key();
    test_glitch();
    test_multi();
    test_release_bounce();
    test_reset_in_pressed();
    test_random_keys();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 passive key matrix by driving one column low at a time and sampling the rows. Debounces a single pressed key and emits its 4-bit code with a one-cycle strobe. It is the input-side counterpart of the multiplexed seven-segment driver: same time-multiplexed scanning, opposite direction. It feeds the stopwatch control and digit-entry logic.

## Interface
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1000, column step rate; TICK_DIV = CLK_HZ/SCAN_HZ, must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive agreeing ticks required for both press and release; must be >= 1.
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- row  in  4  matrix rows, active-low (external pull-ups), asynchronous to clk.
- col  out  4  matrix columns, active-low, exactly one bit low at all times.
- key_code  out  4  code of the accepted key = 4*row_idx + col_idx.
- key_valid  out  1  one-cycle strobe when a debounced press is accepted.
- key_down  out  1  level, high from acceptance until the debounced release.

## Operation
- Rows pass through a 2-flop synchronizer. All decisions use the synchronized value, sampled only on tick.
- tick: one-cycle pulse every TICK_DIV clocks. The first tick occurs TICK_DIV cycles after reset deasserts.
- A row pattern is single if exactly one bit is low. It is idle if it is 4'b1111. Any other pattern is multi.
- States:
  - SCAN: on tick, if the pattern is single, latch col_idx and row_idx, set cnt=1 and go to DEBOUNCE without advancing the column. Otherwise advance col_idx by +1 mod 4.
  - DEBOUNCE: the column is held. On tick, if the pattern equals the latched pattern, increment cnt. When cnt reaches DEBOUNCE_SCANS, accept the key and go to PRESSED with cnt=0. Any other pattern returns to SCAN and advances the column. With DEBOUNCE_SCANS=1, acceptance happens directly from SCAN on the detecting tick.
  - PRESSED: the column is held. On tick, idle increments cnt; non-idle clears cnt. When cnt reaches DEBOUNCE_SCANS, clear key_down, go to SCAN and advance the column.
- Acceptance does three things:
  - key_code <= {row_idx, col_idx}.
  - key_down <= 1.
  - key_valid pulses high for exactly one cycle.
- Multi patterns are never accepted. A second key in another column is invisible while the column is held; the first key locks.
- key_code holds its last value after release.
- Reset values: state SCAN, col_idx 0, col 4'b1110, key_code 0, key_valid 0, key_down 0, cnt 0, tick divider 0, synchronizer 4'b1111.
- Reset mid-operation returns everything to the reset values. A key still held is re-detected and produces a new strobe.

## Timing
- col changes on the clk edge that registers tick. Row sampling uses data synchronized at least TICK_DIV-2 cycles after the column change.
- Press latency: the key is first seen single at tick T0. Acceptance happens at tick T0+(DEBOUNCE_SCANS-1). key_valid and key_down go high on the clock edge after that tick.
- Release latency: key_down falls on the edge after the DEBOUNCE_SCANS-th consecutive idle tick. The scan resumes at the next column.
- No key pressed: col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, with a period of 4*TICK_DIV cycles.

## Structure
- Shared package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, PRESSED};
  - NUM_ROWS=4 and NUM_COLS=4;
  - the col_idx one-hot-low decode function.
- Sub-module scan_tick_gen (CLK_HZ, SCAN_HZ -> one-cycle tick, counter width $clog2(TICK_DIV)). The FSM, synchronizer and outputs stay in keypad_scanner.

## Test plan
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (TICK_DIV=10), DEBOUNCE_SCANS=3. The matrix model pulls row[r] low when key (r,c) is pressed and col[c]=0.
- Reset with no keys -> col=4'b1110, outputs 0. After release, col steps 1110, 1101, 1011, 0111, 1110 at cycles 10, 20, 30, 40.
- Hold key (row 2, col 1) for 100 cycles -> exactly one key_valid with key_code=4'd9, 21 cycles after the detecting tick. key_down=1 until 3 idle ticks after release. Scanning then resumes at col 2.
- Key (row 0, col 3) pressed for one tick only -> no key_valid, key_down stays 0, rotation continues.
- Keys (row 0, col 2) and (row 3, col 2) held together -> no strobe. Then keys (row 1, col 0) and (row 1, col 3) held together -> only code 4'd4 is accepted.
- During PRESSED for code 4'd9, the row goes idle for 2 ticks and then low again -> key_down stays 1, no second strobe.
- Assert reset while in PRESSED with the key held -> outputs clear immediately, col=4'b1110. After release, the key is re-accepted with a new single key_valid.
